// File: rtl/sar_search_8bit.sv
// Successive-approximation search over an 8-bit value using an external
// greater/equal/lesser comparator that sees the registered trial value.
module sar_search_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       A_greater_B,
  input  logic       A_equal_B,
  input  logic       A_lesser_B,
  output logic [7:0] trial,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic [3:0] cycles,
  output logic       err
);

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] trial_q, trial_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] result_q, result_d;
  logic [3:0] cycles_q, cycles_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic [2:0] cmp;
  logic       cmp_onehot;
  logic [7:0] bit_cur;
  logic [7:0] bit_nxt;

  assign cmp        = {A_greater_B, A_equal_B, A_lesser_B};
  assign cmp_onehot = (cmp == 3'b100) || (cmp == 3'b010) || (cmp == 3'b001);
  assign bit_cur    = 8'h01 << idx_q;
  assign bit_nxt    = bit_cur >> 1;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d  = state_q;
    trial_d  = trial_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cycles_d = cycles_q;
    done_d   = 1'b0;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        trial_d = 8'h00;
        if (start) begin
          state_d = SEARCH;
          trial_d = 8'h80;
          idx_d   = 3'd7;
          cnt_d   = 4'd1;
          err_d   = 1'b0;
        end
      end

      SEARCH: begin
        if (!cmp_onehot) begin
          err_d   = 1'b1;
          state_d = IDLE;
          trial_d = 8'h00;
        end else if (A_equal_B) begin
          result_d = trial_q;
          cycles_d = cnt_q;
          done_d   = 1'b1;
          state_d  = IDLE;
          trial_d  = 8'h00;
        end else if (idx_q == 3'd0) begin
          // Last bit decided: lesser means the target sits just below trial;
          // greater means the comparator contradicted an earlier answer.
          if (A_lesser_B) begin
            result_d = trial_q & ~8'h01;
            cycles_d = 4'd8;
            done_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
          trial_d = 8'h00;
        end else begin
          if (A_lesser_B) begin
            trial_d = (trial_q & ~bit_cur) | bit_nxt;
          end else begin
            trial_d = trial_q | bit_nxt;
          end
          idx_d = idx_q - 3'd1;
          cnt_d = cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
        trial_d = 8'h00;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      trial_q  <= 8'h00;
      idx_q    <= 3'd0;
      cnt_q    <= 4'd0;
      result_q <= 8'h00;
      cycles_q <= 4'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cycles_q <= cycles_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign trial  = trial_q;
  assign busy   = (state_q == SEARCH);
  assign done   = done_q;
  assign result = result_q;
  assign cycles = cycles_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sar_search_8bit.sv
// Directed bench for sar_search_8bit: a behavioural comparator answers on the
// live trial value, with an override used to inject inconsistent answers.
module tb_sar_search_8bit;

  logic       clk;
  logic       rst;
  logic       start;
  logic       A_greater_B;
  logic       A_equal_B;
  logic       A_lesser_B;
  logic [7:0] trial;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [3:0] cycles;
  logic       err;

  logic [7:0] target;
  logic       cmp_ovr;
  logic [2:0] ovr_val;

  int n_checks = 0;
  int n_fail   = 0;

  sar_search_8bit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A_greater_B (A_greater_B),
    .A_equal_B   (A_equal_B),
    .A_lesser_B  (A_lesser_B),
    .trial       (trial),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .cycles      (cycles),
    .err         (err)
  );

  assign A_greater_B = cmp_ovr ? ovr_val[2] : (target > trial);
  assign A_equal_B   = cmp_ovr ? ovr_val[1] : (target == trial);
  assign A_lesser_B  = cmp_ovr ? ovr_val[0] : (target < trial);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a search and follows it until busy drops; returns in the done cycle.
  // exp_trials holds the expected trial sequence, first trial in the top byte.
  task automatic run_search(input string tag, input logic [7:0] tgt, input logic repulse,
                            input int exp_n, input logic [63:0] exp_trials,
                            input logic [7:0] exp_res);
    logic [7:0] seen [12];
    int n;
    int early_done;
    target = tgt;
    start  = 1'b1;
    step();
    start  = 1'b0;
    check({tag, " busy_after_start"}, busy, 1'b1);
    n = 0;
    early_done = 0;
    while (busy && n < 12) begin
      seen[n] = trial;
      if (done) early_done++;
      n++;
      start = (repulse && n == 3);
      step();
    end
    start = 1'b0;
    check({tag, " search_len"}, n, exp_n);
    for (int i = 0; i < exp_n && i < n; i++)
      check($sformatf("%s trial%0d", tag, i), seen[i], exp_trials[63-8*i -: 8]);
    check({tag, " no_early_done"}, early_done, 0);
    check({tag, " done"}, done, 1'b1);
    check({tag, " result"}, result, exp_res);
    check({tag, " cycles"}, cycles, exp_n);
    check({tag, " err"}, err, 1'b0);
    check({tag, " idle_trial"}, trial, 8'h00);
  endtask

  task automatic after_done(input string tag, input logic [7:0] exp_res);
    step();
    check({tag, " done_pulse_end"}, done, 1'b0);
    check({tag, " result_held"}, result, exp_res);
    check({tag, " idle"}, busy, 1'b0);
  endtask

  // Runs a search on target 0 and overrides the comparator on one cycle.
  task automatic err_case(input string tag, input int at_cycle, input logic [2:0] bad,
                          input logic [7:0] prev_res);
    target = 8'h00;
    start  = 1'b1;
    step();
    start  = 1'b0;
    check({tag, " err_cleared_by_start"}, err, 1'b0);
    for (int c = 1; c < at_cycle; c++) step();
    cmp_ovr = 1'b1;
    ovr_val = bad;
    step();
    cmp_ovr = 1'b0;
    check({tag, " err"}, err, 1'b1);
    check({tag, " no_done"}, done, 1'b0);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " result_kept"}, result, prev_res);
    check({tag, " trial"}, trial, 8'h00);
    step();
    check({tag, " no_done_later"}, done, 1'b0);
    check({tag, " err_sticky"}, err, 1'b1);
  endtask

  initial begin
    int done_seen;
    rst     = 1'b1;
    start   = 1'b0;
    target  = 8'h00;
    cmp_ovr = 1'b0;
    ovr_val = 3'b000;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("reset trial", trial, 8'h00);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset result", result, 8'h00);
    check("reset cycles", cycles, 4'd0);
    check("reset err", err, 1'b0);
    rst = 1'b0;
    step();
    check("idle_no_start busy", busy, 1'b0);

    run_search("t80", 8'h80, 1'b0, 1, 64'h8000_0000_0000_0000, 8'h80);
    after_done("t80", 8'h80);

    run_search("t00", 8'h00, 1'b0, 8, 64'h8040_2010_0804_0201, 8'h00);
    after_done("t00", 8'h00);

    run_search("tFF", 8'hFF, 1'b0, 8, 64'h80C0_E0F0_F8FC_FEFF, 8'hFF);
    // Start raised during the done cycle launches the next search at once.
    target = 8'h80;
    start  = 1'b1;
    step();
    start  = 1'b0;
    check("back2back busy", busy, 1'b1);
    check("back2back trial", trial, 8'h80);
    check("back2back done_low", done, 1'b0);
    step();
    check("back2back done", done, 1'b1);
    check("back2back result", result, 8'h80);
    check("back2back cycles", cycles, 4'd1);
    after_done("back2back", 8'h80);

    run_search("t5A", 8'h5A, 1'b1, 7, 64'h8040_6050_585C_5A00, 8'h5A);
    after_done("t5A", 8'h5A);

    err_case("gt_eq_c3", 3, 3'b110, 8'h5A);
    err_case("none_c1", 1, 3'b000, 8'h5A);
    err_case("gt_idx0", 8, 3'b100, 8'h5A);

    // Reset on the fourth search cycle aborts the search without a done.
    target = 8'h33;
    start  = 1'b1;
    step();
    start  = 1'b0;
    step();
    step();
    step();
    check("abort busy_before", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort busy", busy, 1'b0);
    check("abort trial", trial, 8'h00);
    check("abort result", result, 8'h00);
    check("abort cycles", cycles, 4'd0);
    check("abort err", err, 1'b0);
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) done_seen++;
      step();
    end
    check("abort no_done", done_seen, 0);
    check("abort stays_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sar_search_8bit.md
SAR_SEARCH_8BIT -- requirements
Module: sar_search_8bit

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 8 bits.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a search; sampled only in IDLE.
REQ-006 A_greater_B  input  1  external comparator result: hidden target > trial.
REQ-007 A_equal_B  input  1  external comparator result: hidden target == trial.
REQ-008 A_lesser_B  input  1  external comparator result: hidden target < trial.
REQ-009 trial  output  8  registered trial value driven to the comparator B input.
REQ-010 busy  output  1  high while in SEARCH.
REQ-011 done  output  1  one-cycle pulse when a search completes with a valid result.
REQ-012 result  output  8  recovered target value; valid from the done pulse until the next accepted start.
REQ-013 cycles  output  4  number of SEARCH cycles used by the last search (1..8).
REQ-014 err  output  1  sticky protocol-error flag; cleared by reset or the next accepted start.

Function
REQ-015 The FSM SHALL have two states: IDLE and SEARCH.
REQ-016 The comparator SHALL be treated as combinational on trial: in SEARCH, the comparator inputs are sampled in the same cycle that trial is presented.
REQ-017 IDLE with start=1 at an edge SHALL produce, on that edge: trial=8'h80, bit index=7, cycle counter=1, err=0, and entry to SEARCH.
REQ-018 In IDLE, the block SHALL hold trial=8'h00 and busy=0.
REQ-019 start asserted while busy SHALL be ignored, with no effect on the search in progress.
REQ-020 SEARCH, A_equal_B=1: the block SHALL set result=trial, cycles=counter, pulse done, and go to IDLE (early termination).
REQ-021 SEARCH, A_greater_B=1, bit index>0: the block SHALL keep the current bit, set the next lower bit, decrement the index, and increment the counter.
REQ-022 SEARCH, A_lesser_B=1, bit index>0: the block SHALL clear the current bit, set the next lower bit, decrement the index, and increment the counter.
REQ-023 SEARCH, A_lesser_B=1, bit index=0: the block SHALL set result=trial with bit0 cleared, cycles=8, pulse done, and go to IDLE.
REQ-024 SEARCH, A_greater_B=1, bit index=0: the block SHALL treat this as an inconsistent comparator; it sets err=1, drives no done, leaves result unchanged, and goes to IDLE.
REQ-025 SEARCH with comparator inputs not exactly one-hot (none or several high): the block SHALL set err=1, drive no done, leave result unchanged, and go to IDLE.
REQ-026 A search SHALL take at most 8 SEARCH cycles, so done appears no later than 8 cycles after the start edge; the minimum is 1 cycle (target 8'h80).
REQ-027 done and err SHALL never be asserted by the same search.
REQ-028 start may be asserted in the cycle that done is high; because the FSM is already in IDLE, the new search SHALL begin at the next edge.

Reset
REQ-029 rst=1 at an edge SHALL force: IDLE, trial=8'h00, busy=0, done=0, result=8'h00, cycles=4'd0, err=0.
REQ-030 rst takes priority over start and over the comparator inputs.
REQ-031 rst asserted mid-search SHALL abort the search with no done pulse.

Verification
REQ-032 The bench SHALL cover: target 8'h80 with a model comparator; start pulse -> done 1 cycle after the start edge, result=8'h80, cycles=1.
REQ-033 The bench SHALL cover: target 8'h00; start -> trials 80,40,20,10,08,04,02,01, then done, result=8'h00, cycles=8.
REQ-034 The bench SHALL cover: target 8'hFF; start -> trials 80,C0,E0,F0,F8,FC,FE,FF, equal on the 8th, result=8'hFF, cycles=8.
REQ-035 The bench SHALL cover: target 8'h5A; start, plus start re-pulsed during SEARCH -> result=8'h5A, cycles=7 (equality on trial 5A), and the extra start is ignored.
REQ-036 The bench SHALL cover: comparator forced to gt=1 and eq=1 on the 3rd cycle -> err=1, no done, busy=0 the following cycle, result keeps its old value.
REQ-037 The bench SHALL cover: rst asserted on the 4th SEARCH cycle -> next cycle busy=0, trial=8'h00, result=8'h00, and no done ever appears for that search.
